// File: rtl/clk_pkg.sv
// ============================================================================
// Module      : clk_pkg
// Description : Shared run-state type and default division ratios for the
//               clock time base and the downstream counter chain.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package clk_pkg;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    localparam int DIV_NORMAL_DEF = 50_000_000;
    localparam int DIV_QUICK_DEF  = 500_000;
    localparam int CNT_W_DEF      = 26;

endpackage

`default_nettype wire

// File: rtl/clk_tick_gen_rise_edge.sv
// ============================================================================
// Module      : rise_edge
// Description : Rising-edge detector: one history flop and an AND gate.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rise_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= RST_VAL;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

`default_nettype wire

// File: rtl/clk_tick_gen.sv
// ============================================================================
// Module      : clk_tick_gen
// Description : Time base producing a one-cycle tick and a square wave with
//               normal/quick rates, run/pause, single-step and phase clear.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clk_tick_gen
    import clk_pkg::*;
#(
    parameter int DIV_NORMAL    = DIV_NORMAL_DEF,
    parameter int DIV_QUICK     = DIV_QUICK_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter bit START_RUNNING = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic quick,
    input  logic toggle,
    input  logic step,
    input  logic clear,
    output logic tick,
    output logic sq_out,
    output logic running
);

    localparam logic [CNT_W-1:0] DIV_N_W   = CNT_W'(DIV_NORMAL);
    localparam logic [CNT_W-1:0] DIV_Q_W   = CNT_W'(DIV_QUICK);
    localparam run_state_t       RST_STATE = START_RUNNING ? RUNNING : PAUSED;

    generate
        if (DIV_NORMAL < 2 || DIV_QUICK < 2 ||
            64'(DIV_NORMAL) >= (64'd1 << CNT_W) ||
            64'(DIV_QUICK)  >= (64'd1 << CNT_W)) begin : g_bad_params
            $error("clk_tick_gen: DIV_NORMAL/DIV_QUICK must be >= 2 and fit in CNT_W bits");
        end
    endgenerate

    run_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             sq_q;
    logic             toggle_q;
    logic             step_q;
    logic             toggle_rise;
    logic             step_rise;
    logic [CNT_W-1:0] div_d;
    logic [CNT_W-1:0] div_m1_d;
    logic [CNT_W-1:0] div_half_d;
    logic             wrap_d;

    // Inputs are registered before edge detection; reset to 1 so a level
    // already high at reset release is not mistaken for a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_q <= 1'b1;
            step_q   <= 1'b1;
        end else begin
            toggle_q <= toggle;
            step_q   <= step;
        end
    end

    rise_edge #(.RST_VAL(1'b1)) u_toggle_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (toggle_q),
        .rise_o (toggle_rise)
    );

    rise_edge #(.RST_VAL(1'b1)) u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (step_q),
        .rise_o (step_rise)
    );

    assign div_d      = quick ? DIV_Q_W : DIV_N_W;
    assign div_m1_d   = div_d - 1'b1;
    assign div_half_d = div_d >> 1;
    assign wrap_d     = (cnt_q >= div_m1_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            sq_q    <= 1'b0;
        end else begin
            if (state_q == RUNNING) begin
                sq_q <= (cnt_q < div_half_d);
            end
            if (clear) begin
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else if (toggle_rise) begin
                state_q <= (state_q == RUNNING) ? PAUSED : RUNNING;
                tick_q  <= 1'b0;
            end else if (state_q == PAUSED) begin
                if (step_rise) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b1;
                end else begin
                    tick_q <= 1'b0;
                end
            end else begin
                cnt_q  <= wrap_d ? '0 : cnt_q + 1'b1;
                tick_q <= wrap_d;
            end
        end
    end

    assign tick    = tick_q;
    assign sq_out  = sq_q;
    assign running = (state_q == RUNNING);

endmodule

`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
// ============================================================================
// Module      : tb_clk_tick_gen
// Description : Self-checking bench for clk_tick_gen with a cycle-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_clk_tick_gen;

    localparam int DN = 10;
    localparam int DQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic quick = 1'b0;
    logic toggle = 1'b0;
    logic step = 1'b0;
    logic clear = 1'b0;
    logic tick1, sq1, run1;
    logic tick0, sq0, run0;

    clk_tick_gen #(.DIV_NORMAL(DN), .DIV_QUICK(DQ), .CNT_W(8), .START_RUNNING(1'b1)) dut_run (
        .clk(clk), .rst(rst), .quick(quick), .toggle(toggle), .step(step), .clear(clear),
        .tick(tick1), .sq_out(sq1), .running(run1)
    );

    clk_tick_gen #(.DIV_NORMAL(DN), .DIV_QUICK(DQ), .CNT_W(8), .START_RUNNING(1'b0)) dut_pause (
        .clk(clk), .rst(rst), .quick(quick), .toggle(toggle), .step(step), .clear(clear),
        .tick(tick0), .sq_out(sq0), .running(run0)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 mirrors dut_run, index 1 mirrors dut_pause.
    int m_cnt [2];
    bit m_tick[2];
    bit m_sq  [2];
    bit m_run [2];
    bit th0 = 1'b1, th1 = 1'b1, sh0 = 1'b1, sh1 = 1'b1;
    bit m_te, m_se;
    int m_div;

    always @(posedge clk) begin
        m_te  = th0 && !th1;
        m_se  = sh0 && !sh1;
        m_div = quick ? DQ : DN;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i]  = 0;
                m_tick[i] = 1'b0;
                m_sq[i]   = 1'b0;
                m_run[i]  = (i == 0);
            end else begin
                if (m_run[i]) m_sq[i] = (m_cnt[i] < m_div / 2);
                if (clear) begin
                    m_cnt[i]  = 0;
                    m_tick[i] = 1'b0;
                end else if (m_te) begin
                    m_run[i]  = !m_run[i];
                    m_tick[i] = 1'b0;
                end else if (!m_run[i]) begin
                    m_tick[i] = m_se;
                    if (m_se) m_cnt[i] = 0;
                end else if (m_cnt[i] >= m_div - 1) begin
                    m_cnt[i]  = 0;
                    m_tick[i] = 1'b1;
                end else begin
                    m_cnt[i]  = m_cnt[i] + 1;
                    m_tick[i] = 1'b0;
                end
            end
        end
        if (rst) begin
            th0 = 1'b1; th1 = 1'b1; sh0 = 1'b1; sh1 = 1'b1;
        end else begin
            th1 = th0; th0 = toggle; sh1 = sh0; sh0 = step;
        end
    end

    function automatic logic [5:0] dut_vec();
        return {tick1, sq1, run1, tick0, sq0, run0};
    endfunction

    function automatic logic [5:0] model_vec();
        return {m_tick[0], m_sq[0], m_run[0], m_tick[1], m_sq[1], m_run[1]};
    endfunction

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step_clk();
        checks++;
        if (dut_vec() !== 6'b001_000) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", dut_vec(), 6'b001_000);
        end
    endtask

    task automatic test_normal();
        int first = 0;
        int sq_hi = 0;
        int ticks = 0;
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL normal_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
            if (tick1 && first == 0) first = n;
            if (n >= 11 && n <= 20 && sq1) sq_hi++;
            if (n >= 11 && tick1) ticks++;
        end
        checks++;
        if (first !== 10) begin
            errors++;
            $display("FAIL first_tick_edge got=%0d exp=%0d", first, 10);
        end
        checks++;
        if (sq_hi !== 5) begin
            errors++;
            $display("FAIL sq_high_cycles got=%0d exp=%0d", sq_hi, 5);
        end
        checks++;
        if (ticks !== 2) begin
            errors++;
            $display("FAIL normal_tick_count got=%0d exp=%0d", ticks, 2);
        end
    endtask

    task automatic test_quick();
        int ticks = 0;
        int guard = 0;
        while (m_cnt[0] != 7 && guard < 20) begin
            step_clk();
            guard++;
        end
        checks++;
        if (m_cnt[0] != 7) begin
            errors++;
            $display("FAIL quick_wait_cnt7 got=%0d exp=%0d", m_cnt[0], 7);
        end
        quick = 1'b1;
        step_clk();
        checks++;
        if (tick1 !== 1'b1) begin
            errors++;
            $display("FAIL quick_early_tick got=%b exp=1", tick1);
        end
        for (int n = 1; n <= 12; n++) begin
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL quick_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
            if (tick1) ticks++;
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL quick_tick_count got=%0d exp=%0d", ticks, 3);
        end
        quick = 1'b0;
    endtask

    task automatic test_toggle();
        int ticks = 0;
        int guard = 0;
        int lat = 0;
        while (m_cnt[0] != 3 && guard < 20) begin
            step_clk();
            guard++;
        end
        toggle = 1'b1;
        step_clk();
        toggle = 1'b0;
        step_clk();
        checks++;
        if (run1 !== 1'b0) begin
            errors++;
            $display("FAIL toggle_pause got=%b exp=0", run1);
        end
        for (int n = 1; n <= 15; n++) begin
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL pause_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
            if (tick1) ticks++;
        end
        checks++;
        if (ticks !== 0) begin
            errors++;
            $display("FAIL paused_ticks got=%0d exp=%0d", ticks, 0);
        end
        toggle = 1'b1;
        step_clk();
        toggle = 1'b0;
        step_clk();
        checks++;
        if (run1 !== 1'b1) begin
            errors++;
            $display("FAIL toggle_resume got=%b exp=1", run1);
        end
        // Frozen at 4, so five more increments then the wrap edge.
        while (!tick1 && lat < 15) begin
            step_clk();
            lat++;
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL resume_tick_latency got=%0d exp=%0d", lat, 6);
        end
    endtask

    task automatic test_step();
        int ticks = 0;
        toggle = 1'b1;
        step_clk();
        toggle = 1'b0;
        step_clk();
        for (int k = 0; k < 3; k++) begin
            step = 1'b1;
            for (int n = 0; n < 4; n++) begin
                step_clk();
                step = 1'b0;
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL step_model k=%0d n=%0d got=%b exp=%b", k, n, dut_vec(), model_vec());
                end
                if (tick1) ticks++;
            end
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("FAIL step_tick_count got=%0d exp=%0d", ticks, 3);
        end
        toggle = 1'b1;
        step_clk();
        toggle = 1'b0;
        step_clk();
        for (int n = 0; n < 20; n++) begin
            step = (n % 3 == 0);
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL step_running_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
        end
        step = 1'b0;
    endtask

    task automatic test_toggle_step_clear();
        int ticks = 0;
        int lat = 0;
        toggle = 1'b1;
        step_clk();
        toggle = 1'b0;
        step_clk();
        step_clk();
        toggle = 1'b1;
        step = 1'b1;
        step_clk();
        toggle = 1'b0;
        step = 1'b0;
        step_clk();
        checks++;
        if ({run1, tick1} !== 2'b10) begin
            errors++;
            $display("FAIL toggle_step_same got=%b exp=%b", {run1, tick1}, 2'b10);
        end
        clear = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step_clk();
            if (tick1) ticks++;
        end
        checks++;
        if (ticks !== 0) begin
            errors++;
            $display("FAIL clear_ticks got=%0d exp=%0d", ticks, 0);
        end
        clear = 1'b0;
        while (!tick1 && lat < 15) begin
            step_clk();
            lat++;
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL clear_first_tick got=%0d exp=%0d", lat, 10);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) quick = ~quick;
            toggle = ($urandom_range(0, 5) == 0);
            step   = ($urandom_range(0, 3) == 0);
            clear  = ($urandom_range(0, 24) == 0);
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
        end
        quick = 1'b0; toggle = 1'b0; step = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        repeat (3) step_clk();
        if (!m_run[0]) begin
            toggle = 1'b1;
            step_clk();
            toggle = 1'b0;
            repeat (2) step_clk();
        end
        while (m_cnt[0] != 6 && guard < 30) begin
            step_clk();
            guard++;
        end
        checks++;
        if (m_cnt[0] != 6 || !m_run[0]) begin
            errors++;
            $display("FAIL reset_mid_setup got=%0d exp=%0d", m_cnt[0], 6);
        end
        rst = 1'b1;
        toggle = 1'b1;
        step_clk();
        checks++;
        if (dut_vec() !== 6'b001_000) begin
            errors++;
            $display("FAIL reset_mid_values got=%b exp=%b", dut_vec(), 6'b001_000);
        end
        step_clk();
        rst = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step_clk();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_mid_model n=%0d got=%b exp=%b", n, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({run1, run0} !== 2'b10) begin
            errors++;
            $display("FAIL toggle_through_reset got=%b exp=%b", {run1, run0}, 2'b10);
        end
        toggle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_quick();
        test_toggle();
        test_step();
        test_toggle_step_clear();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
